// File: rtl/mem_copy_engine_pkg.sv
// Shared types and constants for the memory copy/fill engine.
package mem_copy_engine_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_LEN_WIDTH  = 16;

  // Transfer mode selector.
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  // Engine sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_FILL = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Bus-master copy/fill engine for one port of a negedge-registered dual-port RAM.
// All outputs are registered: the next-state process also computes the next value of
// every output, so memory signals for a state are valid from the edge entering it.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   src_q, dst_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [DATA_WIDTH-1:0]   fill_q;

  logic                    busy_d, done_d, we_d;
  logic [LEN_WIDTH-1:0]    count_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   wdata_d;

  // words_done doubles as the word index: it counts writes issued so far.
  logic [ADDR_WIDTH-1:0]   src_cur, dst_cur;
  logic                    last_word;

  assign src_cur   = src_q + ADDR_WIDTH'(words_done);
  assign dst_cur   = dst_q + ADDR_WIDTH'(words_done);
  assign last_word = (words_done == len_q);

  // Capture transfer parameters on an accepted start.
  always_ff @(posedge clock) begin
    if (reset) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      fill_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      src_q  <= src_addr;
      dst_q  <= dst_addr;
      len_q  <= length;
      fill_q <= fill_value;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      words_done       <= '0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      mem_write_enable <= 1'b0;
    end else begin
      state_q          <= state_d;
      busy             <= busy_d;
      done             <= done_d;
      words_done       <= count_d;
      mem_address      <= addr_d;
      mem_write_data   <= wdata_d;
      mem_write_enable <= we_d;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    we_d    = 1'b0;
    count_d = words_done;
    addr_d  = mem_address;
    wdata_d = mem_write_data;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d = '0;
          if (length == '0) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else if (mode == MODE_COPY) begin
            state_d = ST_RD;
            busy_d  = 1'b1;
            addr_d  = src_addr;
          end else begin
            state_d = ST_FILL;
            busy_d  = 1'b1;
            addr_d  = dst_addr;
            wdata_d = fill_value;
            we_d    = 1'b1;
            count_d = LEN_WIDTH'(1);
          end
        end
      end

      // Read data for this word arrives at the next edge; write it straight back out.
      ST_RD: begin
        state_d = ST_WR;
        busy_d  = 1'b1;
        addr_d  = dst_cur;
        wdata_d = mem_read_data;
        we_d    = 1'b1;
        count_d = words_done + LEN_WIDTH'(1);
      end

      ST_WR: begin
        if (last_word) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RD;
          busy_d  = 1'b1;
          addr_d  = src_cur;
        end
      end

      ST_FILL: begin
        if (last_word) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
          addr_d  = dst_cur;
          wdata_d = fill_q;
          we_d    = 1'b1;
          count_d = words_done + LEN_WIDTH'(1);
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Testbench: engine paired with a negedge-registered RAM and a plain array model.
module tb_mem_copy_engine;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [15:0] src_addr, dst_addr, length, fill_value;
  logic        busy, done, mem_write_enable;
  logic [15:0] words_done, mem_address, mem_write_data;
  logic [15:0] mem_read_data;

  logic [15:0] ram     [0:65535];
  logic [15:0] exp_mem [0:65535];
  logic        ram_init;
  int          wr_count;
  int          n_assert;
  int          n_fail;

  mem_copy_engine dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .mode             (mode),
    .src_addr         (src_addr),
    .dst_addr         (dst_addr),
    .length           (length),
    .fill_value       (fill_value),
    .busy             (busy),
    .done             (done),
    .words_done       (words_done),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  always #5 clock = ~clock;

  // Negedge-registered RAM; read returns the pre-write contents.
  always @(negedge clock) begin
    if (ram_init) begin
      for (int i = 0; i < 65536; i++) ram[i] = exp_mem[i];
      mem_read_data <= '0;
    end else begin
      mem_read_data <= ram[mem_address];
      if (mem_write_enable === 1'b1) ram[mem_address] = mem_write_data;
    end
  end

  // Count write strobes as seen by the RAM.
  always @(negedge clock) begin
    if (mem_write_enable === 1'b1) wr_count <= wr_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: ascending word-by-word transfer on the model array.
  task automatic model_xfer(input logic m, input logic [15:0] s, input logic [15:0] d,
                            input int n, input logic [15:0] f);
    logic [15:0] sa, da;
    for (int i = 0; i < n; i++) begin
      sa = s + 16'(i);
      da = d + 16'(i);
      exp_mem[da] = m ? f : exp_mem[sa];
    end
  endtask

  // Compare RAM against model over dst-1 .. dst+n.
  task automatic chk_window(input string tag, input logic [15:0] d, input int n);
    logic [15:0] a;
    for (int i = -1; i <= n; i++) begin
      a = d + 16'(i);
      chk($sformatf("%s mem[%h]", tag, a), 32'(ram[a]), 32'(exp_mem[a]));
    end
  endtask

  // Run one transfer; poke >= 0 injects a competing start at that cycle.
  task automatic run_xfer(input string tag, input logic m, input logic [15:0] s,
                          input logic [15:0] d, input logic [15:0] n,
                          input logic [15:0] f, input int poke);
    int cyc, w0, exp_lat, limit;
    bit seen, busy_ok;
    exp_lat = (n == 0) ? 0 : (m ? int'(n) : 2 * int'(n));
    limit   = exp_lat + 6;
    @(negedge clock);
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; length = n; fill_value = f;
    w0 = wr_count;
    @(posedge clock); #1;
    start = 1'b0;
    src_addr = 16'($urandom); dst_addr = 16'($urandom);
    length = 16'($urandom); fill_value = 16'($urandom); mode = 1'($urandom);
    chk({tag, " busy_first"}, 32'(busy), 32'(n != 0));
    cyc = 0; seen = (done === 1'b1); busy_ok = 1'b1;
    while (!seen && cyc < limit) begin
      if (cyc == poke) begin
        start = 1'b1; mode = 1'b1; dst_addr = 16'h0900; length = 16'd4; fill_value = 16'hDEAD;
      end
      @(posedge clock); #1;
      start = 1'b0;
      cyc++;
      if (done === 1'b1) seen = 1'b1;
      else if (busy !== 1'b1) busy_ok = 1'b0;
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, " busy_held"}, 32'(busy_ok), 32'd1);
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, " words_done"}, 32'(words_done), 32'(n));
    chk({tag, " writes"}, 32'(wr_count - w0), 32'(n));
    @(posedge clock); #1;
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    chk({tag, " words_held"}, 32'(words_done), 32'(n));
    model_xfer(m, s, d, int'(n), f);
    chk_window(tag, d, int'(n));
  endtask

  initial begin
    int cyc, w0, mism;
    logic [15:0] rs, rd, rn, rf;
    logic rm;
    n_assert = 0; n_fail = 0; wr_count = 0;
    reset = 1'b1; start = 1'b0; mode = 1'b0; ram_init = 1'b1;
    src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
    for (int i = 0; i < 65536; i++) exp_mem[i] = 16'($urandom);
    exp_mem[16'h0100] = 16'hAAAA; exp_mem[16'h0101] = 16'hBBBB;
    exp_mem[16'h0102] = 16'hCCCC; exp_mem[16'h0103] = 16'hDDDD;
    @(negedge clock); #1 ram_init = 1'b0;
    @(posedge clock); #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset we", 32'(mem_write_enable), 32'd0);
    chk("reset words_done", 32'(words_done), 32'd0);
    chk("reset addr", 32'(mem_address), 32'd0);
    chk("reset wdata", 32'(mem_write_data), 32'd0);
    @(negedge clock); reset = 1'b0;

    run_xfer("copy4", 1'b0, 16'h0100, 16'h0200, 16'd4, 16'h0, -1);
    chk("copy4 word3", 32'(ram[16'h0203]), 32'h0000DDDD);
    run_xfer("fill3", 1'b1, 16'h0, 16'h0300, 16'd3, 16'hBEEF, -1);
    chk("fill3 word0", 32'(ram[16'h0300]), 32'h0000BEEF);
    run_xfer("len0copy", 1'b0, 16'h0100, 16'h0600, 16'd0, 16'h0, -1);
    run_xfer("len0fill", 1'b1, 16'h0, 16'h0610, 16'd0, 16'h5555, -1);
    run_xfer("fillwrap", 1'b1, 16'h0, 16'hFFFE, 16'd4, 16'h1234, -1);
    chk("fillwrap 0001", 32'(ram[16'h0001]), 32'h00001234);
    run_xfer("copywrap", 1'b0, 16'hFFFD, 16'h1000, 16'd6, 16'h0, -1);
    run_xfer("overlap", 1'b0, 16'h0400, 16'h0402, 16'd6, 16'h0, -1);
    run_xfer("samesd", 1'b0, 16'h0500, 16'h0500, 16'd3, 16'h0, -1);
    run_xfer("busystart", 1'b0, 16'h0700, 16'h0800, 16'd5, 16'h0, 3);
    chk_window("busystart untouched", 16'h0900, 4);

    // Reset in the middle of an 8-word copy, after three words have been written.
    @(negedge clock);
    start = 1'b1; mode = 1'b0; src_addr = 16'h0A00; dst_addr = 16'h0B00; length = 16'd8;
    w0 = wr_count;
    @(posedge clock); #1 start = 1'b0;
    cyc = 0;
    while (words_done !== 16'd3 && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk("rst reach3", 32'(words_done), 32'd3);
    @(negedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;
    chk("rst we", 32'(mem_write_enable), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst words_done", 32'(words_done), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    @(negedge clock); reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("rst writes", 32'(wr_count - w0), 32'd3);
    chk("rst idle busy", 32'(busy), 32'd0);
    model_xfer(1'b0, 16'h0A00, 16'h0B00, 3, 16'h0);
    chk_window("rst", 16'h0B00, 8);

    // Randomized transfers across the whole address space.
    for (int k = 0; k < 10; k++) begin
      rm = 1'($urandom);
      rs = 16'($urandom);
      rd = 16'($urandom);
      rn = 16'($urandom_range(1, 24));
      rf = 16'($urandom);
      run_xfer($sformatf("rand%0d", k), rm, rs, rd, rn, rf, -1);
    end

    mism = 0;
    for (int i = 0; i < 65536; i++) if (ram[i] !== exp_mem[i]) mism++;
    chk("full sweep mismatches", 32'(mism), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
